mmio_mult_unit: RTL and testbench

Memory-mapped iterative signed multiplier on the single-cycle MIPS data-memory bus, alongside `data_memory`. It consumes the CPU's `dm_address`/`dm_d`/`dm_we` and returns read data plus a hit flag, so the top level can mux `dm_q` and suppress the RAM write. Software multiply routines (e.g. the mult program) use it instead of shift-add loops: write operands, start, poll done, read the 64-bit product.

---
 rtl/mmio_mult_unit_pkg.sv | 27 ++
 rtl/mmio_mult_unit_if.sv | 20 ++
 rtl/mult_iter_core.sv | 78 +++++++
 rtl/mmio_mult_unit.sv | 85 ++++++++
 tb/tb_mmio_mult_unit.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/mmio_mult_unit_pkg.sv
// rtl/mmio_mult_unit_pkg.sv - shared types and register map for the MMIO multiplier
// Purpose: FSM state type, register offsets and CTRL bit indices shared by
//          mmio_mult_unit and mult_iter_core.
// Ports:   none (package).
package definitions_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mult_state_t;

  localparam logic [4:0] MULT_OPA   = 5'h00;
  localparam logic [4:0] MULT_OPB   = 5'h04;
  localparam logic [4:0] MULT_CTRL  = 5'h08;
  localparam logic [4:0] MULT_RESLO = 5'h0C;
  localparam logic [4:0] MULT_RESHI = 5'h10;

  localparam int CTRL_START = 0;
  localparam int CTRL_DONE  = 1;

  // Magnitude of a signed 32-bit value; -2^31 maps to 2^31 unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mmio_mult_unit_if.sv
// rtl/mmio_mult_unit_if.sv - data-memory bus bundle between CPU and MMIO multiplier
// Purpose: groups the CPU data-memory request and the MMIO response.
// Signals: dm_address/dm_d/dm_we (CPU -> unit), mmio_hit/mmio_q (unit -> CPU).
interface mmio_mult_unit_if;
  logic [15:0] dm_address;
  logic [31:0] dm_d;
  logic        dm_we;
  logic        mmio_hit;
  logic [31:0] mmio_q;

  modport master (
    output dm_address, dm_d, dm_we,
    input  mmio_hit, mmio_q
  );

  modport slave (
    input  dm_address, dm_d, dm_we,
    output mmio_hit, mmio_q
  );
endinterface

// File: rtl/mult_iter_core.sv
// rtl/mult_iter_core.sv - iterative 32x32 signed shift-add multiplier core
// Purpose: multiplies magnitudes one bit per cycle, then applies the sign.
// Ports:   clk, asyn_n_rst (async active-low), start (accepted only in IDLE),
//          a/b signed operands, busy (state != IDLE), done_pulse (high during
//          FIX, i.e. the cycle before the result edge), product (signed result,
//          valid while done_pulse is high).
module mult_iter_core
  import definitions_pkg::*;
(
  input  logic        clk,
  input  logic        asyn_n_rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done_pulse,
  output logic [63:0] product
);

  mult_state_t r_state;
  mult_state_t w_next;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [63:0] r_acc;
  logic [4:0]  r_cnt;
  logic        r_sign;

  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) r_state <= IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    done_pulse = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = CALC;
      CALC: if (r_cnt == 5'd31) w_next = FIX;
      FIX: begin
        done_pulse = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Multiplicand shifts left instead of indexing by cnt, so each step is a plain add.
  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_mcand  <= {32'd0, abs32(a)};
          r_mplier <= abs32(b);
          r_sign   <= a[31] ^ b[31];
          r_acc    <= '0;
          r_cnt    <= '0;
        end
        CALC: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign product = r_sign ? (~r_acc + 64'd1) : r_acc;

endmodule

// File: rtl/mmio_mult_unit.sv
// rtl/mmio_mult_unit.sv - memory-mapped signed multiplier on the data-memory bus
// Purpose: register file (OPA, OPB, CTRL/STATUS, RES_LO, RES_HI), address
//          decode and combinational read mux around mult_iter_core.
// Ports:   clk, asyn_n_rst (async active-low), bus (slave modport:
//          dm_address/dm_d/dm_we in, mmio_hit/mmio_q out), busy out.
module mmio_mult_unit
  import definitions_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0800
) (
  input  logic              clk,
  input  logic              asyn_n_rst,
  mmio_mult_unit_if.slave   bus,
  output logic              busy
);

  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic [31:0] r_res_lo;
  logic [31:0] r_res_hi;
  logic        r_done;

  logic [4:0]  w_off;
  logic        w_wr;
  logic        w_start;
  logic        w_busy;
  logic        w_done_pulse;
  logic [63:0] w_product;

  // Byte lanes [1:0] are masked so any byte address in a word decodes the word.
  assign w_off        = bus.dm_address[4:0] & 5'b11100;
  assign bus.mmio_hit = (bus.dm_address[15:5] == BASE_ADDR[15:5]);
  assign w_wr         = bus.dm_we & bus.mmio_hit;
  assign w_start      = w_wr && (w_off == MULT_CTRL) && bus.dm_d[CTRL_START] && !w_busy;

  mult_iter_core u_core (
    .clk        (clk),
    .asyn_n_rst (asyn_n_rst),
    .start      (w_start),
    .a          (r_opa),
    .b          (r_opb),
    .busy       (w_busy),
    .done_pulse (w_done_pulse),
    .product    (w_product)
  );

  always_ff @(posedge clk or negedge asyn_n_rst) begin
    if (!asyn_n_rst) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_done   <= 1'b0;
    end else begin
      if (w_wr && !w_busy && (w_off == MULT_OPA)) r_opa <= bus.dm_d;
      if (w_wr && !w_busy && (w_off == MULT_OPB)) r_opb <= bus.dm_d;
      if (w_done_pulse) begin
        r_res_lo <= w_product[31:0];
        r_res_hi <= w_product[63:32];
      end
      // Completion outranks a same-edge clear so a finished result is never lost.
      if (w_done_pulse)
        r_done <= 1'b1;
      else if (w_start || (w_wr && (w_off == MULT_CTRL) && bus.dm_d[CTRL_DONE]))
        r_done <= 1'b0;
    end
  end

  always_comb begin
    bus.mmio_q = '0;
    if (bus.mmio_hit) begin
      case (w_off)
        MULT_OPA:   bus.mmio_q = r_opa;
        MULT_OPB:   bus.mmio_q = r_opb;
        MULT_CTRL:  bus.mmio_q = {30'd0, r_done, w_busy};
        MULT_RESLO: bus.mmio_q = r_res_lo;
        MULT_RESHI: bus.mmio_q = r_res_hi;
        default:    bus.mmio_q = '0;
      endcase
    end
  end

  assign busy = w_busy;

endmodule

// File: tb/tb_mmio_mult_unit.sv
// tb/tb_mmio_mult_unit.sv - directed self-checking bench for mmio_mult_unit
module tb_mmio_mult_unit;

  logic clk = 1'b0;
  logic asyn_n_rst = 1'b0;
  logic busy;
  int   tests = 0;
  int   failed = 0;

  mmio_mult_unit_if bus ();

  mmio_mult_unit #(.BASE_ADDR(16'h0800)) dut (
    .clk        (clk),
    .asyn_n_rst (asyn_n_rst),
    .bus        (bus),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] A_OPA   = 16'h0800;
  localparam logic [15:0] A_OPB   = 16'h0804;
  localparam logic [15:0] A_CTRL  = 16'h0808;
  localparam logic [15:0] A_RESLO = 16'h080C;
  localparam logic [15:0] A_RESHI = 16'h0810;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] data);
    bus.dm_address = addr;
    bus.dm_d       = data;
    bus.dm_we      = 1'b1;
    @(posedge clk);
    #1;
    bus.dm_we      = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    bus.dm_address = addr;
    #1;
    check(tag, bus.mmio_q, exp);
  endtask

  // Counts edges until busy drops; bounded so a stuck FSM still reaches the summary.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;

  initial begin
    bus.dm_address = '0;
    bus.dm_d       = '0;
    bus.dm_we      = 1'b0;
    repeat (2) @(posedge clk);
    #1 asyn_n_rst = 1'b1;

    // Reset clears a written operand
    wr(A_OPA, 32'd5);
    rd_check("opa_before_reset", A_OPA, 32'd5);
    #2 asyn_n_rst = 1'b0;
    #3 asyn_n_rst = 1'b1;
    rd_check("opa_reset", A_OPA, 32'd0);
    rd_check("opb_reset", A_OPB, 32'd0);
    rd_check("status_reset", A_CTRL, 32'd0);
    rd_check("reslo_reset", A_RESLO, 32'd0);
    rd_check("reshi_reset", A_RESHI, 32'd0);
    check("busy_reset", {31'd0, busy}, 32'd0);

    // 9 * -11 = -99
    @(posedge clk); #1;
    wr(A_OPA, 32'd9);
    wr(A_OPB, 32'hFFFF_FFF5);
    wr(A_CTRL, 32'h1);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    rd_check("status_busy", A_CTRL, 32'h1);
    wait_idle(n);
    check("latency_9x-11", n, 32'd33);
    rd_check("status_done", A_CTRL, 32'h2);
    rd_check("reslo_9x-11", A_RESLO, 32'hFFFF_FF9D);
    rd_check("reshi_9x-11", A_RESHI, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h2);
    rd_check("status_cleared", A_CTRL, 32'h0);

    // -2^31 * -2^31 = 2^62
    wr(A_OPA, 32'h8000_0000);
    wr(A_OPB, 32'h8000_0000);
    wr(A_CTRL, 32'h3);
    rd_check("status_start_and_clear", A_CTRL, 32'h1);
    wait_idle(n);
    rd_check("reslo_min_sq", A_RESLO, 32'h0000_0000);
    rd_check("reshi_min_sq", A_RESHI, 32'h4000_0000);

    // (2^31-1) * -2^31 = -(2^62 - 2^31); result regs persist across a new start
    wr(A_OPA, 32'h7FFF_FFFF);
    wr(A_CTRL, 32'h1);
    rd_check("reshi_held_during_busy", A_RESHI, 32'h4000_0000);
    wait_idle(n);
    rd_check("reslo_max_min", A_RESLO, 32'h8000_0000);
    rd_check("reshi_max_min", A_RESHI, 32'hC000_0000);

    // Operand write and restart while busy are ignored
    wr(A_OPA, 32'd100);
    wr(A_OPB, 32'd3);
    wr(A_CTRL, 32'h1);
    wr(A_OPA, 32'd3);
    wr(A_CTRL, 32'h1);
    rd_check("opa_kept_busy", A_OPA, 32'd100);
    wait_idle(n);
    check("latency_restart_ignored", n, 32'd31);
    rd_check("reslo_100x3", A_RESLO, 32'd300);
    rd_check("reshi_100x3", A_RESHI, 32'd0);

    // Reset mid-operation aborts with nothing visible
    wr(A_CTRL, 32'h1);
    repeat (10) @(posedge clk);
    #1 asyn_n_rst = 1'b0;
    #1;
    check("busy_abort", {31'd0, busy}, 32'd0);
    rd_check("status_abort", A_CTRL, 32'h0);
    rd_check("reslo_abort", A_RESLO, 32'd0);
    rd_check("reshi_abort", A_RESHI, 32'd0);
    #2 asyn_n_rst = 1'b1;
    @(posedge clk); #1;
    wr(A_OPA, 32'd7);
    wr(A_OPB, 32'd6);
    wr(A_CTRL, 32'h1);
    wait_idle(n);
    check("latency_7x6", n, 32'd33);
    rd_check("reslo_7x6", A_RESLO, 32'd42);
    rd_check("reshi_7x6", A_RESHI, 32'd0);

    // Unmapped offsets and out-of-window addresses
    rd_check("q_unmapped_14", 16'h0814, 32'd0);
    check("hit_0814", {31'd0, bus.mmio_hit}, 32'd1);
    rd_check("q_outside_0004", 16'h0004, 32'd0);
    check("hit_0004", {31'd0, bus.mmio_hit}, 32'd0);
    rd_check("q_byte_offset", 16'h080D, 32'd42);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
